// File: rtl/fft_c1.sv
// Purpose: column-1 stage of the 32-point radix-2 DIT FFT (span-2 butterflies, twiddles 1 and -j).
// Latency: 1 clock, registered output; a new 32-element vector is accepted every cycle.
// Backpressure: none, free-running stage with no handshake; output clears asynchronously on reset.
module fft_c1 (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] inpmac,
  output logic [2047:0] outmac
);

  // Combinational butterfly results for all 32 elements, before the output register.
  logic [2047:0] bfly;

  // Eight identical, independent groups of four elements: base b = 4g.
  // Element k sits at [64k+63:64k]; real half is the upper 32 bits.
  for (genvar g = 0; g < 8; g++) begin : grp
    localparam int B = 4 * g;

    logic [31:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;

    assign x0r = inpmac[64*(B+0)+32 +: 32];
    assign x0i = inpmac[64*(B+0)    +: 32];
    assign x1r = inpmac[64*(B+1)+32 +: 32];
    assign x1i = inpmac[64*(B+1)    +: 32];
    assign x2r = inpmac[64*(B+2)+32 +: 32];
    assign x2i = inpmac[64*(B+2)    +: 32];
    assign x3r = inpmac[64*(B+3)+32 +: 32];
    assign x3i = inpmac[64*(B+3)    +: 32];

    // Twiddle 1 pair (b, b+2): plain sum and difference.
    assign bfly[64*(B+0)+32 +: 32] = x0r + x2r;
    assign bfly[64*(B+0)    +: 32] = x0i + x2i;
    assign bfly[64*(B+2)+32 +: 32] = x0r - x2r;
    assign bfly[64*(B+2)    +: 32] = x0i - x2i;

    // Twiddle -j pair (b+1, b+3): -j*x3 = (x3.im, -x3.re), so no multiplier,
    // just a swap of real/imag with the sign folded into add vs subtract.
    assign bfly[64*(B+1)+32 +: 32] = x1r + x3i;
    assign bfly[64*(B+1)    +: 32] = x1i - x3r;
    assign bfly[64*(B+3)+32 +: 32] = x1r - x3i;
    assign bfly[64*(B+3)    +: 32] = x1i + x3r;
  end

  // Output register: clears immediately on reset, otherwise captures every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outmac <= '0;
    end else begin
      outmac <= bfly;
    end
  end

endmodule

// File: tb/tb_fft_c1.sv
module tb_fft_c1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2047:0] inpmac = '0;
  logic [2047:0] outmac;

  int errors = 0;
  int checks = 0;

  fft_c1 dut (
    .clk    (clk),
    .reset  (reset),
    .inpmac (inpmac),
    .outmac (outmac)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] el(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  // Compare a whole 2048-bit vector; on mismatch report the first differing element.
  task automatic chk(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    int k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      k = 0;
      for (int i = 31; i >= 0; i--) begin
        if (obs[64*i +: 64] !== exp[64*i +: 64]) k = i;
      end
      $error("FAIL %s: element %0d observed %h expected %h", tag, k, obs[64*k +: 64], exp[64*k +: 64]);
    end
  endtask

  task automatic chk_el(input string tag, input int k, input logic [63:0] exp);
    logic [63:0] obs;
    obs = outmac[64*k +: 64];
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: element %0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Drive a new vector mid-cycle, confirm the output is unchanged before the
  // edge, then confirm the new result appears exactly one edge later.
  task automatic step(input string tag, input logic [2047:0] vec,
                      input logic [2047:0] exp, input logic [2047:0] prev);
    inpmac = vec;
    #2;
    chk({tag, "_hold"}, outmac, prev);
    @(posedge clk);
    #1;
    chk(tag, outmac, exp);
  endtask

  logic [2047:0] v_t1, e_t1, v_tj, e_tj, v_wr, e_wr, v_nw, e_nw, v_on, e_on, v_g7, e_g7;

  initial begin
    // Stimulus vectors and hand-computed expected results.
    v_t1 = '0; v_t1[64*0 +: 64] = el(32'd1, 32'd0); v_t1[64*2 +: 64] = el(32'd2, 32'd0);
    e_t1 = '0; e_t1[64*0 +: 64] = el(32'd3, 32'd0); e_t1[64*2 +: 64] = el(32'hFFFFFFFF, 32'd0);

    v_tj = '0; v_tj[64*1 +: 64] = el(32'd5, 32'd7); v_tj[64*3 +: 64] = el(32'd2, 32'd3);
    e_tj = '0; e_tj[64*1 +: 64] = el(32'd8, 32'd5); e_tj[64*3 +: 64] = el(32'd2, 32'd9);

    v_wr = '0; v_wr[64*0 +: 64] = el(32'h7FFFFFFF, 32'd0); v_wr[64*2 +: 64] = el(32'h00000001, 32'd0);
    e_wr = '0; e_wr[64*0 +: 64] = el(32'h80000000, 32'd0); e_wr[64*2 +: 64] = el(32'h7FFFFFFE, 32'd0);

    // -j pair wrap: x1 = (0, 0x80000000), x3 = (1, 0) in group 3 (b = 12).
    v_nw = '0; v_nw[64*13 +: 64] = el(32'd0, 32'h80000000); v_nw[64*15 +: 64] = el(32'd1, 32'd0);
    e_nw = '0; e_nw[64*13 +: 64] = el(32'd0, 32'h7FFFFFFF); e_nw[64*15 +: 64] = el(32'd0, 32'h80000001);

    v_on = '0; e_on = '0;
    for (int k = 0; k < 32; k++) v_on[64*k +: 64] = el(32'd1, 32'd1);
    for (int b = 0; b < 32; b += 4) begin
      e_on[64*(b+0) +: 64] = el(32'd2, 32'd2);
      e_on[64*(b+1) +: 64] = el(32'd2, 32'd0);
      e_on[64*(b+2) +: 64] = el(32'd0, 32'd0);
      e_on[64*(b+3) +: 64] = el(32'd0, 32'd2);
    end

    v_g7 = '0; v_g7[64*28 +: 64] = el(32'd4, 32'd0); v_g7[64*30 +: 64] = el(32'd1, 32'd0);
    e_g7 = '0; e_g7[64*28 +: 64] = el(32'd5, 32'd0); e_g7[64*30 +: 64] = el(32'd3, 32'd0);

    // Reset asserted between edges with arbitrary input clears output at once.
    for (int k = 0; k < 32; k++) inpmac[64*k +: 64] = el(32'hDEADBEEF, 32'hCAFEF00D + k);
    #2 reset = 1'b1;
    #1;
    chk("reset_async", outmac, '0);
    @(posedge clk);
    #1;
    chk("reset_held", outmac, '0);

    // Release reset; the first edge loads the current input.
    inpmac = v_t1;
    #1 reset = 1'b0;
    #2;
    chk("release_no_edge", outmac, '0);
    @(posedge clk);
    #1;
    chk("twiddle1", outmac, e_t1);
    chk_el("t1_out0", 0, el(32'd3, 32'd0));
    chk_el("t1_out2", 2, el(32'hFFFFFFFF, 32'd0));

    // Back-to-back vectors, one per cycle.
    step("twiddle_mj", v_tj, e_tj, e_t1);
    chk_el("tj_out1", 1, el(32'd8, 32'd5));
    chk_el("tj_out3", 3, el(32'd2, 32'd9));
    step("wrap", v_wr, e_wr, e_tj);
    chk_el("wrap_out0", 0, el(32'h80000000, 32'd0));
    chk_el("wrap_out2", 2, el(32'h7FFFFFFE, 32'd0));
    step("wrap_mj", v_nw, e_nw, e_wr);
    step("ones", v_on, e_on, e_nw);
    for (int b = 0; b < 32; b += 4) begin
      chk_el("ones_b0", b + 0, el(32'd2, 32'd2));
      chk_el("ones_b1", b + 1, el(32'd2, 32'd0));
      chk_el("ones_b2", b + 2, el(32'd0, 32'd0));
      chk_el("ones_b3", b + 3, el(32'd0, 32'd2));
    end
    // Constant input holds a constant output.
    @(posedge clk);
    #1;
    chk("ones_hold", outmac, e_on);
    step("group7", v_g7, e_g7, e_on);
    step("twiddle1_again", v_t1, e_t1, e_g7);

    // Mid-operation reset: in-flight result discarded, output clears immediately.
    inpmac = v_tj;
    #2 reset = 1'b1;
    #1;
    chk("midreset_async", outmac, '0);
    @(posedge clk);
    #1;
    chk("midreset_edge", outmac, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("after_midreset", outmac, e_tj);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
